// File: rtl/energy_window_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : energy_window_sum_pkg
// Description : Shared RX constants for the energy / packet-detection path
//               and the FILL/RUN state encoding of the window accumulator.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package energy_window_sum_pkg;

  // Width of |A|^2 as produced by the energy computation stage.
  localparam int ENERGY_W     = 17;
  // Window length shared with the packet detector's correlator.
  localparam int DET_WIN_LEN  = 16;
  localparam int DET_WIN_LOG2 = 4;

  // Accumulator control states.
  localparam logic [0:0] c_FILL = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/energy_window_sum_if.sv
`default_nettype none
// ============================================================================
// Module      : energy_window_sum_if
// Description : Sample stream in / windowed sum out bundle for
//               energy_window_sum.
// Ports       : master drives InputEnable, DataMagnitude, Clear and receives
//               OutputEnable, EnergySum, WindowFull; slave is the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
interface energy_window_sum_if
  import energy_window_sum_pkg::*;
#(
  parameter int IN_W  = ENERGY_W,
  parameter int OUT_W = ENERGY_W + DET_WIN_LOG2
);
  logic             InputEnable;
  logic [IN_W-1:0]  DataMagnitude;
  logic             Clear;
  logic             OutputEnable;
  logic [OUT_W-1:0] EnergySum;
  logic             WindowFull;

  modport master (
    output InputEnable, DataMagnitude, Clear,
    input  OutputEnable, EnergySum, WindowFull
  );

  modport slave (
    input  InputEnable, DataMagnitude, Clear,
    output OutputEnable, EnergySum, WindowFull
  );
endinterface
`default_nettype wire

// File: rtl/energy_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : energy_delay_line
// Description : WIN_LEN-deep circular register file holding the last WIN_LEN
//               accepted energies. Oldest is the entry about to be
//               overwritten, i.e. the sample leaving the window.
// Ports       : Clk, Rst_n (async active-low), Clear (sync flush),
//               WrEn/WrData (write at WrPtr, advance), Oldest (comb read).
// Revision    : 1.0 - initial release
// ============================================================================
module energy_delay_line #(
  parameter int WIN_LEN  = 16,
  parameter int WIN_LOG2 = 4,
  parameter int IN_W     = 17
) (
  input  wire logic            Clk,
  input  wire logic            Rst_n,
  input  wire logic            Clear,
  input  wire logic            WrEn,
  input  wire logic [IN_W-1:0] WrData,
  output logic      [IN_W-1:0] Oldest
);

  logic [IN_W-1:0]     r_line [WIN_LEN];
  logic [WIN_LOG2-1:0] r_wrPtr;

  // Entries must return to zero on Clear so that subtracting Oldest during
  // the refill is a no-op for the accumulator.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < WIN_LEN; i++) r_line[i] <= '0;
      r_wrPtr <= '0;
    end else if (Clear) begin
      for (int i = 0; i < WIN_LEN; i++) r_line[i] <= '0;
      r_wrPtr <= '0;
    end else if (WrEn) begin
      r_line[r_wrPtr] <= WrData;
      // Power-of-two depth: natural wrap from WIN_LEN-1 to 0.
      r_wrPtr         <= r_wrPtr + WIN_LOG2'(1);
    end
  end

  assign Oldest = r_line[r_wrPtr];

endmodule
`default_nettype wire

// File: rtl/energy_window_sum.sv
`default_nettype none
// ============================================================================
// Module      : energy_window_sum
// Description : Sliding-window sum of the last WIN_LEN accepted energy
//               samples (running add/subtract over a circular delay line).
//               One-cycle latency, one sample per clock.
// Ports       : Clk, Rst_n (async active-low),
//               bus (slave): InputEnable, DataMagnitude, Clear in;
//                            OutputEnable, EnergySum, WindowFull out.
// Revision    : 1.0 - initial release
// ============================================================================
module energy_window_sum
  import energy_window_sum_pkg::*;
#(
  parameter int WIN_LEN  = DET_WIN_LEN,
  parameter int WIN_LOG2 = DET_WIN_LOG2,
  parameter int IN_W     = ENERGY_W,
  parameter int OUT_W    = IN_W + WIN_LOG2
) (
  input wire logic           Clk,
  input wire logic           Rst_n,
  energy_window_sum_if.slave bus
);

  localparam int c_FILL_W = WIN_LOG2 + 1;
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(WIN_LEN);
  localparam logic [c_FILL_W-1:0] c_FILL_PRE = c_FILL_W'(WIN_LEN - 1);

  logic [0:0]          r_state;
  logic [0:0]          w_stateNext;
  logic [c_FILL_W-1:0] r_fillCnt;
  logic [OUT_W-1:0]    r_acc;
  logic                r_outputEnable;
  logic                w_accept;
  logic                w_emit;
  logic [IN_W-1:0]     w_oldest;

  // Clear outranks InputEnable: the coincident sample is dropped.
  assign w_accept = bus.InputEnable & ~bus.Clear;

  energy_delay_line #(
    .WIN_LEN  (WIN_LEN),
    .WIN_LOG2 (WIN_LOG2),
    .IN_W     (IN_W)
  ) u_line (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Clear  (bus.Clear),
    .WrEn   (w_accept),
    .WrData (bus.DataMagnitude),
    .Oldest (w_oldest)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= c_FILL;
    else        r_state <= w_stateNext;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_stateNext = r_state;
    if (bus.Clear)
      w_stateNext = c_FILL;
    else if (r_state == c_FILL && w_accept && r_fillCnt == c_FILL_PRE)
      w_stateNext = c_RUN;
  end

  // ---------------- FSM: outputs ----------------
  // The sample that completes the window already produces an output, so
  // decide on the next state rather than the current one.
  always_comb begin
    w_emit = 1'b0;
    if (w_accept && w_stateNext == c_RUN)
      w_emit = 1'b1;
  end

  // ---------------- Datapath ----------------
  // Oldest is already contained in r_acc, so the subtraction cannot wrap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_acc          <= '0;
      r_fillCnt      <= '0;
      r_outputEnable <= 1'b0;
    end else if (bus.Clear) begin
      r_acc          <= '0;
      r_fillCnt      <= '0;
      r_outputEnable <= 1'b0;
    end else begin
      r_outputEnable <= w_emit;
      if (w_accept) begin
        r_acc <= r_acc + OUT_W'(bus.DataMagnitude) - OUT_W'(w_oldest);
        if (r_fillCnt != c_FILL_MAX)
          r_fillCnt <= r_fillCnt + c_FILL_W'(1);
      end
    end
  end

  assign bus.OutputEnable = r_outputEnable;
  assign bus.EnergySum    = r_acc;
  assign bus.WindowFull   = (r_fillCnt == c_FILL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_energy_window_sum.sv
`default_nettype none
// ============================================================================
// Module      : tb_energy_window_sum
// Description : Directed self-checking bench for energy_window_sum: fill,
//               slide, gaps, Clear, maximum input, asynchronous reset.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_energy_window_sum;

  localparam int WIN_LEN = 16;
  localparam int IN_W    = 17;
  localparam int OUT_W   = 21;
  localparam int MAXV    = 131071;  // 0x1FFFF

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  int tests   = 0;
  int fails   = 0;
  int cnt     = 0;    // accepted samples since reset/Clear, saturating
  int lastSum = -1;   // known EnergySum value, -1 when not defined

  energy_window_sum_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  energy_window_sum #(
    .WIN_LEN  (WIN_LEN),
    .WIN_LOG2 (4),
    .IN_W     (IN_W),
    .OUT_W    (OUT_W)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input int d, input logic clr);
    bus.InputEnable   = en;
    bus.DataMagnitude = IN_W'(d);
    bus.Clear         = clr;
    @(posedge Clk);
    #1;
    bus.InputEnable = 1'b0;
    bus.Clear       = 1'b0;
  endtask

  task automatic feed(input int d, input int expSum);
    drive(1'b1, d, 1'b0);
    cnt = (cnt < WIN_LEN) ? cnt + 1 : WIN_LEN;
    chk("oe", bus.OutputEnable, (cnt == WIN_LEN));
    chk("full", bus.WindowFull, (cnt == WIN_LEN));
    if (expSum >= 0) chk("sum", bus.EnergySum, expSum);
    lastSum = expSum;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 0, 1'b0);
      chk("gap_oe", bus.OutputEnable, 0);
      chk("gap_full", bus.WindowFull, (cnt == WIN_LEN));
      if (lastSum >= 0) chk("gap_sum", bus.EnergySum, lastSum);
    end
  endtask

  task automatic do_clear(input logic withSample, input int d);
    drive(withSample, d, 1'b1);
    cnt = 0;
    chk("clr_oe", bus.OutputEnable, 0);
    chk("clr_sum", bus.EnergySum, 0);
    chk("clr_full", bus.WindowFull, 0);
    lastSum = 0;
  endtask

  initial begin
    bus.InputEnable   = 1'b0;
    bus.DataMagnitude = '0;
    bus.Clear         = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_oe", bus.OutputEnable, 0);
    chk("rst_sum", bus.EnergySum, 0);
    chk("rst_full", bus.WindowFull, 0);
    Rst_n = 1'b1;

    // Fill: 20 x 100, first output on the 16th sample
    for (int i = 1; i <= 20; i++) feed(100, (i >= 16) ? 1600 : -1);

    // Clear with a coincident 500 (discarded), then 16 x 50 -> 800
    do_clear(1'b1, 500);
    for (int i = 1; i <= 16; i++) feed(50, (i == 16) ? 800 : -1);

    // Slide: 16 x 100 then 16 x 200 -> 1600, 1700 .. 3200
    do_clear(1'b0, 0);
    for (int i = 1; i <= 16; i++) feed(100, (i == 16) ? 1600 : -1);
    for (int k = 1; k <= 16; k++) feed(200, 1600 + 100 * k);

    // Same stream with 1..3 idle cycles between samples
    do_clear(1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      feed(100, (i == 16) ? 1600 : -1);
      idle(int'($urandom_range(1, 3)));
    end
    for (int k = 1; k <= 16; k++) begin
      feed(200, 1600 + 100 * k);
      idle(int'($urandom_range(1, 3)));
    end

    // Max input: steady 0x1FFFF0
    do_clear(1'b0, 0);
    for (int i = 1; i <= 40; i++) feed(MAXV, (i >= 16) ? 16 * MAXV : -1);

    // 10 x 7 sliding into a full window of maxima, then async reset mid-run
    for (int k = 1; k <= 10; k++) feed(7, (16 - k) * MAXV + 7 * k);
    Rst_n = 1'b0;
    #1;
    chk("arst_oe", bus.OutputEnable, 0);
    chk("arst_sum", bus.EnergySum, 0);
    chk("arst_full", bus.WindowFull, 0);
    @(posedge Clk);
    #1;
    Rst_n   = 1'b1;
    cnt     = 0;
    lastSum = 0;
    for (int i = 1; i <= 16; i++) feed(7, (i == 16) ? 112 : -1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/energy_window_sum.md
# energy_window_sum

Sliding-window accumulator for the RX packet-detection path. It consumes the per-sample energy stream |A|² (17-bit) produced by the energy computation stage. It outputs the running sum of the most recent WIN_LEN valid energies, which the downstream packet detector uses as the normalising power term. Internal storage is a WIN_LEN-deep circular delay line with a running add/subtract accumulator, so each sample costs one add, one subtract and one register write.

## Interface
- WIN_LEN, 16, window length in valid samples; must be a power of two, range 4..64
- WIN_LOG2, 4, log2(WIN_LEN)
- IN_W, 17, input energy width
- OUT_W, 21, output sum width; must equal IN_W + WIN_LOG2

- Clk  in  1  single clock, all logic rising-edge
- Rst_n  in  1  asynchronous, active-low reset
- InputEnable  in  1  DataMagnitude valid this cycle
- DataMagnitude  in  IN_W  energy sample, treated as unsigned (MSB is 0 by construction upstream)
- Clear  in  1  synchronous flush: empties the window, sum returns to 0
- OutputEnable  out  1  EnergySum valid, one-cycle pulse per accepted sample once the window is full
- EnergySum  out  OUT_W  unsigned sum of the last WIN_LEN accepted samples
- WindowFull  out  1  level, high once WIN_LEN samples have been accepted since reset or Clear

## Operation
- Delay line: WIN_LEN × IN_W registers. WrPtr is WIN_LOG2 bits and wraps from WIN_LEN-1 to 0.
- Accepted sample (InputEnable=1, Clear=0):
  - Oldest = Line[WrPtr]
  - Line[WrPtr] <= DataMagnitude
  - WrPtr <= WrPtr+1
  - Acc <= Acc + DataMagnitude − Oldest
- During fill, entries are still 0 from reset or Clear, so subtracting Oldest is a no-op. No special-case logic is needed.
- FillCnt counts 0..WIN_LEN and saturates at WIN_LEN. WindowFull = (FillCnt == WIN_LEN).
- Two states:
  - FILL: FillCnt < WIN_LEN. No OutputEnable.
  - RUN: window full. OutputEnable follows every accepted sample.
  - FILL→RUN on the accepted sample that makes FillCnt = WIN_LEN. That sample itself produces an OutputEnable.
  - RUN→FILL only on Clear or reset.
- InputEnable=0: all state holds; OutputEnable=0; EnergySum holds its last value.
- Clear (any state, with or without InputEnable):
  - All Line entries, Acc, WrPtr and FillCnt go to 0.
  - The coincident input sample is discarded.
  - Next cycle: OutputEnable=0, EnergySum=0, WindowFull=0.
- Arithmetic: Acc is OUT_W bits unsigned. The subtraction never underflows because Oldest is already contained in Acc. Maximum value is WIN_LEN·(2^IN_W−1), which fits OUT_W bits, so no saturation logic is needed.

## Timing
- Reset values:
  - OutputEnable=0, EnergySum=0, WindowFull=0
  - Line=0, Acc=0, WrPtr=0, FillCnt=0
- Latency: one cycle. Sample accepted at edge n → EnergySum/OutputEnable valid after edge n+1, and EnergySum includes that sample.
- Throughput: one sample per clock. Back-to-back InputEnable is supported, and arbitrary gaps are allowed.
- Reset asserted mid-stream clears everything immediately (asynchronous). The first post-reset output requires WIN_LEN fresh samples.
- Priority: Rst_n > Clear > InputEnable.

## Structure
- Shared RX package holds the constants:
  - ENERGY_W = 17, the width shared with the energy stage
  - DET_WIN_LEN = 16 and DET_WIN_LOG2 = 4, shared with the packet detector, which uses the same window length for its correlator
- Optional sub-module: `energy_delay_line`. It contains the circular register file and WrPtr, and returns Oldest combinationally. Acc, FillCnt and the FILL/RUN control stay in the top.
- Expected size: 150–250 lines.

## Test plan
- Fill: reset, then 20 back-to-back samples of 100 → first OutputEnable on the 16th sample with EnergySum=1600. Samples 17–20 each give 1600. WindowFull rises with the first OutputEnable.
- Slide: 16×100 then 16×200 back-to-back → outputs step 1600, 1700, 1800, …, 3200, increasing by 100 per sample.
- Gaps: same stream as the slide scenario, with InputEnable low for 1–3 random cycles between samples → identical EnergySum sequence. OutputEnable=0 and EnergySum held during gaps.
- Clear: 20×100, then Clear asserted together with a sample of 500 → next cycle EnergySum=0, WindowFull=0, the 500 is discarded. A further 16×50 → first output 800.
- Max: 40 samples of 0x1FFFF → steady EnergySum = 0x1FFFF0 with no wrap.
- Reset mid-run: Rst_n pulsed low after 10 samples → all outputs 0 immediately. 16 further samples of 7 → first output 112.
